spi_sequencer: RTL and testbench

//  Drives spi_frontend for multi-byte transfers issued by the register/Wishbone layer.
//  - Owns the SPI clock prescaler: generates prescaled_clk, high_pulse and low_pulse.
//  - Frames a burst of length_i bytes under one chip-select assertion.
//  - Hands TX bytes to the frontend one at a time and returns RX bytes.
//  - Sits between the register block (TX/RX streams) and spi_frontend (internal interface).

---
 rtl/spi_pkg.sv | 21 ++
 rtl/spi_prescaler.sv | 61 ++++++
 rtl/spi_sequencer.sv | 196 +++++++++++++++++++
 tb/tb_spi_sequencer.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : spi_pkg
//  Description : Shared types and constants for the SPI burst sequencer.
//                Defines the sequencer state encoding and the SPI byte width.
//  Revision    : 1.0 - initial release
// ============================================================================
package spi_pkg;

    localparam int SPI_BYTE_W = 8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        FETCH = 3'd2,
        SHIFT = 3'd3,
        HOLD  = 3'd4
    } spi_seq_state_t;

endpackage
`default_nettype wire

// File: rtl/spi_prescaler.sv
`default_nettype none
// ============================================================================
//  Module      : spi_prescaler
//  Description : Divides the system clock down to the SPI bit clock.
//                The count runs from 0 up to presc_i. On reaching presc_i it
//                wraps and toggles the registered SPI clock, so one SPI period
//                is 2*(presc_i+1) system cycles. The edge pulses are
//                registered alongside the clock, so each pulse is high in the
//                same cycle the clock shows its new level.
//  Ports       : clk_i, rst_i      - system clock, synchronous active-high reset
//                en_i              - run; when low, counter and clock held at 0
//                presc_i           - half-period minus 1, in clk cycles
//                prescaled_clk_o   - divided SPI clock
//                high_pulse_o      - 1-cycle strobe at the 0->1 edge
//                low_pulse_o       - 1-cycle strobe at the 1->0 edge
//  Revision    : 1.0 - initial release
// ============================================================================
module spi_prescaler #(
    parameter int PRESC_W = 8
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               en_i,
    input  logic [PRESC_W-1:0] presc_i,
    output logic               prescaled_clk_o,
    output logic               high_pulse_o,
    output logic               low_pulse_o
);

    logic [PRESC_W-1:0] r_cnt;
    logic               r_clk;
    logic               r_high;
    logic               r_low;

    always_ff @(posedge clk_i) begin
        if (rst_i || !en_i) begin
            r_cnt  <= '0;
            r_clk  <= 1'b0;
            r_high <= 1'b0;
            r_low  <= 1'b0;
        end else begin
            r_high <= 1'b0;
            r_low  <= 1'b0;
            if (r_cnt == presc_i) begin
                r_cnt  <= '0;
                r_clk  <= ~r_clk;
                // Pulse direction follows the level the clock is leaving.
                r_high <= ~r_clk;
                r_low  <= r_clk;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign prescaled_clk_o = r_clk;
    assign high_pulse_o    = r_high;
    assign low_pulse_o     = r_low;

endmodule
`default_nettype wire

// File: rtl/spi_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : spi_sequencer
//  Description : Frames multi-byte SPI bursts for spi_frontend. Holds chip
//                select for the whole burst, feeds TX bytes to the frontend
//                one at a time, returns RX bytes and owns the SPI prescaler.
//  Ports       : clk_i, rst_i              - clock, synchronous active-high reset
//                start_i, length_i,
//                prescaler_i, abort_i      - burst control from register layer
//                tx_valid_i, tx_data_i,
//                tx_ready_o                - TX byte stream (valid/ready)
//                rx_valid_o, rx_data_o     - RX byte strobe (no backpressure)
//                busy_o, done_o            - status
//                cs_o, prescaled_clk_o,
//                high_pulse_o, low_pulse_o,
//                transmit_o, transmit_data_o,
//                received_data_i,
//                transmit_done_i           - spi_frontend interface
//  Revision    : 1.0 - initial release
// ============================================================================
module spi_sequencer
    import spi_pkg::*;
#(
    parameter int LEN_W   = 16,
    parameter int PRESC_W = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic [LEN_W-1:0]      length_i,
    input  logic [PRESC_W-1:0]    prescaler_i,
    input  logic                  abort_i,
    input  logic                  tx_valid_i,
    input  logic [SPI_BYTE_W-1:0] tx_data_i,
    output logic                  tx_ready_o,
    output logic                  rx_valid_o,
    output logic [SPI_BYTE_W-1:0] rx_data_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  cs_o,
    output logic                  prescaled_clk_o,
    output logic                  high_pulse_o,
    output logic                  low_pulse_o,
    output logic                  transmit_o,
    output logic [SPI_BYTE_W-1:0] transmit_data_o,
    input  logic [SPI_BYTE_W-1:0] received_data_i,
    input  logic                  transmit_done_i
);

    spi_seq_state_t        r_state;
    spi_seq_state_t        w_next_state;
    logic [LEN_W-1:0]      r_len;
    logic [PRESC_W-1:0]    r_presc;
    logic [SPI_BYTE_W-1:0] r_tx_data;
    logic [SPI_BYTE_W-1:0] r_rx_data;
    logic                  r_transmit;
    logic                  r_rx_valid;
    logic                  r_done;
    logic                  r_abort_pend;

    logic                  w_tx_ready;
    logic                  w_accept;
    logic                  w_byte_done;
    logic                  w_finish;
    logic                  w_presc_en;
    logic                  w_low;

    // The prescaler only runs while the burst stays active across the
    // coming edge; this keeps it cleared in every IDLE cycle, including
    // the first one after a burst ends or is aborted.
    assign w_presc_en = (r_state != IDLE) && (w_next_state != IDLE);

    spi_prescaler #(
        .PRESC_W (PRESC_W)
    ) u_prescaler (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .en_i            (w_presc_en),
        .presc_i         (r_presc),
        .prescaled_clk_o (prescaled_clk_o),
        .high_pulse_o    (high_pulse_o),
        .low_pulse_o     (w_low)
    );

    assign low_pulse_o = w_low;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_tx_ready   = 1'b0;
        w_accept     = 1'b0;
        w_byte_done  = 1'b0;
        w_finish     = 1'b0;
        case (r_state)
            IDLE: begin
                if (start_i && (length_i != '0)) begin
                    w_next_state = SETUP;
                end
            end
            SETUP: begin
                if (abort_i) begin
                    w_next_state = IDLE;
                end else if (w_low) begin
                    w_next_state = FETCH;
                end
            end
            FETCH: begin
                // Ready is withdrawn under abort so the TX source never
                // sees a handshake for a byte that is dropped.
                w_tx_ready = !abort_i;
                if (abort_i) begin
                    w_next_state = IDLE;
                end else if (tx_valid_i) begin
                    w_accept     = 1'b1;
                    w_next_state = SHIFT;
                end
            end
            SHIFT: begin
                if (transmit_done_i) begin
                    w_byte_done = 1'b1;
                    if (abort_i || r_abort_pend) begin
                        w_next_state = IDLE;
                    end else if (r_len == LEN_W'(1)) begin
                        w_next_state = HOLD;
                    end else begin
                        w_next_state = FETCH;
                    end
                end
            end
            HOLD: begin
                if (abort_i) begin
                    w_next_state = IDLE;
                end else if (w_low) begin
                    w_finish     = 1'b1;
                    w_next_state = IDLE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_len        <= '0;
            r_presc      <= '0;
            r_tx_data    <= '0;
            r_rx_data    <= '0;
            r_transmit   <= 1'b0;
            r_rx_valid   <= 1'b0;
            r_done       <= 1'b0;
            r_abort_pend <= 1'b0;
        end else begin
            r_transmit <= w_accept;
            r_rx_valid <= w_byte_done;
            r_done     <= w_finish;
            if ((r_state == IDLE) && (w_next_state == SETUP)) begin
                r_len   <= length_i;
                r_presc <= prescaler_i;
            end
            if (w_accept) begin
                r_tx_data <= tx_data_i;
            end
            // SHIFT is only entered with r_len >= 1, so this cannot wrap.
            if (w_byte_done) begin
                r_rx_data <= received_data_i;
                r_len     <= r_len - 1'b1;
            end
            // An abort during SHIFT waits for the byte in flight to finish.
            if (w_next_state == IDLE) begin
                r_abort_pend <= 1'b0;
            end else if ((r_state == SHIFT) && abort_i) begin
                r_abort_pend <= 1'b1;
            end
        end
    end

    assign tx_ready_o      = w_tx_ready;
    assign rx_valid_o      = r_rx_valid;
    assign rx_data_o       = r_rx_data;
    assign busy_o          = (r_state != IDLE);
    assign done_o          = r_done;
    assign cs_o            = (r_state != IDLE);
    assign transmit_o      = r_transmit;
    assign transmit_data_o = r_tx_data;

endmodule
`default_nettype wire

// File: tb/tb_spi_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_spi_sequencer
//  Description : Self-checking bench for spi_sequencer with a behavioural
//                spi_frontend stand-in wired as a loopback (each byte sent
//                returns unchanged after eight SPI bit periods).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_sequencer;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] length = '0;
    logic [7:0]  presc = '0;
    logic        abort = 1'b0;
    logic        tx_valid = 1'b0;
    logic [7:0]  tx_data = '0;

    logic        tx_ready_o, rx_valid_o, busy_o, done_o, cs_o;
    logic        prescaled_clk_o, high_pulse_o, low_pulse_o, transmit_o;
    logic [7:0]  rx_data_o, transmit_data_o;
    logic [7:0]  fe_rx;
    logic        fe_done;

    spi_sequencer #(.LEN_W(16), .PRESC_W(8)) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .start_i         (start),
        .length_i        (length),
        .prescaler_i     (presc),
        .abort_i         (abort),
        .tx_valid_i      (tx_valid),
        .tx_data_i       (tx_data),
        .tx_ready_o      (tx_ready_o),
        .rx_valid_o      (rx_valid_o),
        .rx_data_o       (rx_data_o),
        .busy_o          (busy_o),
        .done_o          (done_o),
        .cs_o            (cs_o),
        .prescaled_clk_o (prescaled_clk_o),
        .high_pulse_o    (high_pulse_o),
        .low_pulse_o     (low_pulse_o),
        .transmit_o      (transmit_o),
        .transmit_data_o (transmit_data_o),
        .received_data_i (fe_rx),
        .transmit_done_i (fe_done)
    );

    // Frontend stand-in: one bit per SPI period, loopback data.
    logic [7:0] fe_data;
    int         fe_bits;
    logic       fe_active;
    always @(posedge clk) begin
        fe_done <= 1'b0;
        if (rst) begin
            fe_active <= 1'b0;
            fe_bits   <= 0;
            fe_data   <= '0;
            fe_rx     <= '0;
        end else if (transmit_o) begin
            fe_active <= 1'b1;
            fe_data   <= transmit_data_o;
            fe_bits   <= 0;
        end else if (fe_active && low_pulse_o) begin
            if (fe_bits == 7) begin
                fe_active <= 1'b0;
                fe_done   <= 1'b1;
                fe_rx     <= fe_data;
            end else begin
                fe_bits <= fe_bits + 1;
            end
        end
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Scoreboard and monitor.
    logic [7:0] sb_q[$];
    int  rx_count = 0, done_count = 0, tx_count = 0;
    int  cs_rise = 0, cs_fall = 0, stall_tx = 0, stall_cs_low = 0;
    int  cyc = 0, last_high = -1;
    int  cur_presc = 0;
    bit  in_stall = 1'b0;
    bit  prev_low = 1'b0, prev_cs = 1'b0;

    always @(negedge clk) begin
        cyc++;
        if (!rst) begin
            if (rx_valid_o) begin
                rx_count++;
                if (sb_q.size() == 0) check("rx_unexpected", 32'(rx_data_o), 32'hFFFF_FFFF);
                else check("rx_data", 32'(rx_data_o), 32'(sb_q.pop_front()));
            end
            if (done_o) begin
                done_count++;
                check("done_cs_low", 32'(cs_o), 32'd0);
                check("done_after_low_pulse", 32'(prev_low), 32'd1);
            end
            if (transmit_o) begin
                tx_count++;
                if (in_stall) stall_tx++;
            end
            if (in_stall && !cs_o) stall_cs_low++;
            if (cs_o && !prev_cs) cs_rise++;
            if (!cs_o && prev_cs) cs_fall++;
            if (!busy_o) last_high = -1;
            if (high_pulse_o) begin
                if (last_high >= 0) check("presc_period", 32'(cyc - last_high), 32'(2 * (cur_presc + 1)));
                last_high = cyc;
            end
        end
        prev_low = low_pulse_o;
        prev_cs  = cs_o;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input logic [15:0] len, input logic [7:0] p);
        start  = 1'b1;
        length = len;
        presc  = p;
        tick();
        start  = 1'b0;
    endtask

    task automatic wait_ready();
        bit seen = 1'b0;
        for (int w = 0; w < 4000 && !seen; w++) begin
            @(negedge clk);
            if (tx_ready_o) seen = 1'b1;
            else tick();
        end
        if (!seen) check("wait_ready_timeout", 32'd0, 32'd1);
        else tick();
    endtask

    task automatic send_byte(input logic [7:0] d);
        bit ok = 1'b0;
        tx_valid = 1'b1;
        tx_data  = d;
        for (int w = 0; w < 4000 && !ok; w++) begin
            @(negedge clk);
            if (tx_ready_o) begin
                ok = 1'b1;
                sb_q.push_back(d);
            end
            tick();
        end
        tx_valid = 1'b0;
        if (!ok) check("tx_accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_idle();
        bit idle = 1'b0;
        for (int w = 0; w < 5000 && !idle; w++) begin
            @(negedge clk);
            if (!busy_o) idle = 1'b1;
        end
        if (!idle) check("wait_idle_timeout", 32'd0, 32'd1);
        repeat (3) tick();
    endtask

    typedef struct {
        logic [15:0] len;
        logic [7:0]  presc;
        logic [7:0]  base;
        int          stall_idx;
        int          stall_cyc;
        int          exp_rx;
        int          exp_done;
    } vec_t;

    vec_t vecs[5];
    int rx0, d0, t0, r0, f0, st0, sc0, hi;

    initial begin
        vecs[0] = '{len:16'd1, presc:8'd3, base:8'hA5, stall_idx:-1, stall_cyc:0,  exp_rx:1, exp_done:1};
        vecs[1] = '{len:16'd4, presc:8'd0, base:8'h01, stall_idx:-1, stall_cyc:0,  exp_rx:4, exp_done:1};
        vecs[2] = '{len:16'd3, presc:8'd1, base:8'h40, stall_idx:1,  stall_cyc:50, exp_rx:3, exp_done:1};
        vecs[3] = '{len:16'd2, presc:8'd5, base:8'hFE, stall_idx:-1, stall_cyc:0,  exp_rx:2, exp_done:1};
        vecs[4] = '{len:16'd5, presc:8'd2, base:8'h80, stall_idx:-1, stall_cyc:0,  exp_rx:5, exp_done:1};

        // Reset: outputs all zero, prescaled clock quiet while idle.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outputs",
              32'({tx_ready_o, rx_valid_o, busy_o, done_o, cs_o, prescaled_clk_o,
                   high_pulse_o, low_pulse_o, transmit_o, rx_data_o, transmit_data_o}), 32'd0);
        tick();
        rst = 1'b0;
        hi = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (prescaled_clk_o || busy_o) hi++;
        end
        check("idle_clk_quiet", 32'(hi), 32'd0);
        tick();

        // Table-driven bursts.
        for (int v = 0; v < 5; v++) begin
            rx0 = rx_count; d0 = done_count; t0 = tx_count; r0 = cs_rise; f0 = cs_fall;
            st0 = stall_tx; sc0 = stall_cs_low;
            cur_presc = int'(vecs[v].presc);
            pulse_start(vecs[v].len, vecs[v].presc);
            for (int i = 0; i < int'(vecs[v].len); i++) begin
                if (i == vecs[v].stall_idx) begin
                    wait_ready();
                    in_stall = 1'b1;
                    repeat (vecs[v].stall_cyc) tick();
                    in_stall = 1'b0;
                end
                send_byte(vecs[v].base + 8'(i));
            end
            wait_idle();
            check($sformatf("v%0d_rx_count", v),   32'(rx_count - rx0),   32'(vecs[v].exp_rx));
            check($sformatf("v%0d_done_count", v), 32'(done_count - d0),  32'(vecs[v].exp_done));
            check($sformatf("v%0d_transmits", v),  32'(tx_count - t0),    32'(vecs[v].len));
            check($sformatf("v%0d_cs_rises", v),   32'(cs_rise - r0),     32'd1);
            check($sformatf("v%0d_cs_falls", v),   32'(cs_fall - f0),     32'd1);
            check($sformatf("v%0d_sb_empty", v),   32'(sb_q.size()),      32'd0);
            check($sformatf("v%0d_stall_tx", v),   32'(stall_tx - st0),   32'd0);
            check($sformatf("v%0d_stall_cs", v),   32'(stall_cs_low - sc0), 32'd0);
            check($sformatf("v%0d_idle_clk", v),   32'(prescaled_clk_o),  32'd0);
        end

        // Abort in FETCH with a simultaneous TX offer: byte not taken.
        rx0 = rx_count; d0 = done_count; t0 = tx_count;
        cur_presc = 1;
        pulse_start(16'd5, 8'd1);
        send_byte(8'h11);
        wait_ready();
        abort    = 1'b1;
        tx_valid = 1'b1;
        tx_data  = 8'h22;
        @(negedge clk);
        check("abort_fetch_ready_masked", 32'(tx_ready_o), 32'd0);
        tick();
        abort    = 1'b0;
        tx_valid = 1'b0;
        @(negedge clk);
        check("abort_fetch_busy", 32'({busy_o, cs_o}), 32'd0);
        repeat (10) tick();
        check("abort_fetch_rx",   32'(rx_count - rx0),  32'd1);
        check("abort_fetch_done", 32'(done_count - d0), 32'd0);
        check("abort_fetch_tx",   32'(tx_count - t0),   32'd1);
        check("abort_fetch_sb",   32'(sb_q.size()),     32'd0);

        // Abort in SHIFT: byte in flight completes and is returned.
        rx0 = rx_count; d0 = done_count; t0 = tx_count;
        pulse_start(16'd3, 8'd1);
        send_byte(8'h33);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        @(negedge clk);
        check("abort_shift_still_busy", 32'(busy_o), 32'd1);
        wait_idle();
        check("abort_shift_rx",   32'(rx_count - rx0),  32'd1);
        check("abort_shift_done", 32'(done_count - d0), 32'd0);
        check("abort_shift_tx",   32'(tx_count - t0),   32'd1);
        check("abort_shift_sb",   32'(sb_q.size()),     32'd0);

        // Zero-length start is ignored.
        pulse_start(16'd0, 8'd2);
        hi = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (busy_o) hi++;
        end
        check("len0_ignored", 32'(hi), 32'd0);
        tick();

        // Start while busy is ignored: length and prescaler keep first values.
        rx0 = rx_count; d0 = done_count; t0 = tx_count;
        cur_presc = 3;
        pulse_start(16'd2, 8'd3);
        tick();
        pulse_start(16'd7, 8'd0);
        send_byte(8'h5A);
        send_byte(8'hC3);
        wait_idle();
        check("busy_start_rx",   32'(rx_count - rx0),  32'd2);
        check("busy_start_done", 32'(done_count - d0), 32'd1);
        check("busy_start_tx",   32'(tx_count - t0),   32'd2);
        check("busy_start_sb",   32'(sb_q.size()),     32'd0);

        // Reset mid-burst drops chip select at the next edge.
        pulse_start(16'd4, 8'd2);
        repeat (5) tick();
        rst = 1'b1;
        tick();
        @(negedge clk);
        check("reset_mid_burst", 32'({busy_o, cs_o, prescaled_clk_o}), 32'd0);
        tick();
        rst = 1'b0;
        repeat (2) tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
